// File: rtl/anim_ctrl_encoder_if.sv
// Pin-side bundle of the front-panel controller: raw encoder/button inputs and the
// speed/direction control word handed to the animation core.
interface anim_ctrl_encoder_if;
    logic       enc_a;
    logic       enc_b;
    logic       btn_dir;
    logic [3:0] speed;
    logic       dir;
    logic       upd;
    logic       err;

    modport master (
        output enc_a, enc_b, btn_dir,
        input  speed, dir, upd, err
    );

    modport slave (
        input  enc_a, enc_b, btn_dir,
        output speed, dir, upd, err
    );
endinterface

// File: rtl/anim_ctrl_encoder.sv
// Quadrature encoder + pushbutton front end: synchronise, debounce, decode into a
// saturating 4-bit speed and a toggling direction bit with update/error pulses.
module anim_ctrl_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SPEED_RESET     = 0
) (
    input logic               clk,
    input logic               rst,
    anim_ctrl_encoder_if.slave ctrl_io
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    // Bit order of the per-input vectors: 0 = enc_a, 1 = enc_b, 2 = btn_dir.
    logic [2:0]      raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      deb_q, deb_d;
    logic [CntW-1:0] cnt_q [3];
    logic [CntW-1:0] cnt_d [3];

    logic [1:0]        prev_q, cur_ab, delta;
    logic              btn_prev_q;
    logic signed [2:0] acc_q, acc_d;
    logic signed [3:0] acc_ext, acc_sum, step;
    logic [3:0]        speed_q, speed_d;
    logic              dir_q, dir_d, upd_q, upd_d, err_q, err_d;
    logic              cw_detent, ccw_detent;

    assign raw = {ctrl_io.btn_dir, ctrl_io.enc_b, ctrl_io.enc_a};

    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        logic [1:0] p;
        unique case (ab)
            2'b00: p = 2'd0;
            2'b01: p = 2'd1;
            2'b11: p = 2'd2;
            2'b10: p = 2'd3;
        endcase
        return p;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Position difference mod 4: 1 = CW, 3 = CCW, 2 = both bits flipped (illegal).
    always_comb begin
        cur_ab  = {deb_q[0], deb_q[1]};
        delta   = quad_pos(cur_ab) - quad_pos(prev_q);
        step    = 4'sd0;
        if (delta == 2'd1) step = 4'sd1;
        if (delta == 2'd3) step = -4'sd1;
        err_d   = (delta == 2'd2);
        acc_ext = {acc_q[2], acc_q};
        acc_sum = acc_ext + step;

        cw_detent  = !err_d && (acc_sum == 4'sd4);
        ccw_detent = !err_d && (acc_sum == -4'sd4);

        if (err_d || cw_detent || ccw_detent) acc_d = 3'sd0;
        else                                  acc_d = acc_sum[2:0];

        speed_d = speed_q;
        if (cw_detent && speed_q != 4'd15) speed_d = speed_q + 4'd1;
        if (ccw_detent && speed_q != 4'd0) speed_d = speed_q - 4'd1;

        dir_d = dir_q ^ (deb_q[2] & ~btn_prev_q);
        upd_d = (speed_d != speed_q) || (dir_d != dir_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            prev_q     <= 2'b00;
            btn_prev_q <= 1'b0;
            acc_q      <= 3'sd0;
            speed_q    <= 4'(SPEED_RESET);
            dir_q      <= 1'b0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            prev_q     <= cur_ab;
            btn_prev_q <= deb_q[2];
            acc_q      <= acc_d;
            speed_q    <= speed_d;
            dir_q      <= dir_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
        end
    end

    assign ctrl_io.speed = speed_q;
    assign ctrl_io.dir   = dir_q;
    assign ctrl_io.upd   = upd_q;
    assign ctrl_io.err   = err_q;

endmodule

// File: tb/tb_anim_ctrl_encoder.sv
// Directed bench for anim_ctrl_encoder with DEBOUNCE_CYCLES=4, SPEED_RESET=0.
module tb_anim_ctrl_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;
    int   upd_cnt = 0;
    int   err_cnt = 0;
    int   enc_pos = 0;

    anim_ctrl_encoder_if bus ();

    anim_ctrl_encoder #(
        .DEBOUNCE_CYCLES(4),
        .SPEED_RESET    (0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_io(bus)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle; a pulse held two cycles counts twice.
    always @(negedge clk) begin
        if (bus.upd === 1'b1) upd_cnt <= upd_cnt + 1;
        if (bus.err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] gray(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic apply_pos();
        logic [1:0] ab;
        ab = gray(enc_pos);
        bus.enc_a = ab[1];
        bus.enc_b = ab[0];
    endtask

    task automatic cw_step();
        enc_pos = (enc_pos + 1) % 4;
        apply_pos();
        tick(10);
    endtask

    task automatic ccw_step();
        enc_pos = (enc_pos + 3) % 4;
        apply_pos();
        tick(10);
    endtask

    task automatic cw_detent();
        repeat (4) cw_step();
    endtask

    task automatic ccw_detent();
        repeat (4) ccw_step();
    endtask

    task automatic test_reset();
        int u0, e0;
        rst = 1'b1;
        bus.enc_a = 1'b0; bus.enc_b = 1'b0; bus.btn_dir = 1'b0;
        tick(3);
        n_run++; if (bus.speed !== 4'd0) begin n_fail++; $display("FAIL reset_speed got %0d want 0", bus.speed); end
        n_run++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir got %b want 0", bus.dir); end
        n_run++; if (bus.upd !== 1'b0) begin n_fail++; $display("FAIL reset_upd got %b want 0", bus.upd); end
        n_run++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
        rst = 1'b0;
        u0 = upd_cnt; e0 = err_cnt;
        tick(20);
        n_run++; if (upd_cnt - u0 !== 0) begin n_fail++; $display("FAIL idle_upd got %0d want 0", upd_cnt - u0); end
        n_run++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL idle_err got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_cw_saturate();
        int u0, exp_s, exp_u, lat;
        bit found;
        for (int i = 0; i < 17; i++) begin
            u0 = upd_cnt;
            if (i == 0) begin
                repeat (3) cw_step();
                enc_pos = (enc_pos + 1) % 4;
                apply_pos();
                found = 1'b0; lat = -1;
                for (int k = 0; k < 16; k++) begin
                    @(posedge clk); #1;
                    if (!found && bus.upd === 1'b1) begin found = 1'b1; lat = k; end
                end
                n_run++;
                if (!found || lat != 6) begin
                    n_fail++; $display("FAIL cw_latency got edge %0d want edge 6", lat);
                end
            end else begin
                cw_detent();
            end
            exp_s = (i + 1 > 15) ? 15 : i + 1;
            exp_u = (i < 15) ? 1 : 0;
            n_run++;
            if (bus.speed !== 4'(exp_s)) begin
                n_fail++; $display("FAIL cw_speed[%0d] got %0d want %0d", i, bus.speed, exp_s);
            end
            n_run++;
            if (upd_cnt - u0 !== exp_u) begin
                n_fail++; $display("FAIL cw_upd[%0d] got %0d want %0d", i, upd_cnt - u0, exp_u);
            end
        end
    endtask

    task automatic test_ccw_partial();
        int u0, exp_s, exp_u;
        rst = 1'b1; tick(2); rst = 1'b0; tick(2);
        n_run++; if (bus.speed !== 4'd0) begin n_fail++; $display("FAIL ccw_reset_speed got %0d want 0", bus.speed); end
        repeat (3) cw_detent();
        n_run++; if (bus.speed !== 4'd3) begin n_fail++; $display("FAIL ccw_start_speed got %0d want 3", bus.speed); end
        u0 = upd_cnt;
        cw_step(); cw_step(); ccw_step(); ccw_step();
        n_run++; if (bus.speed !== 4'd3) begin n_fail++; $display("FAIL partial_speed got %0d want 3", bus.speed); end
        n_run++; if (upd_cnt - u0 !== 0) begin n_fail++; $display("FAIL partial_upd got %0d want 0", upd_cnt - u0); end
        u0 = upd_cnt;
        ccw_detent();
        n_run++; if (bus.speed !== 4'd2) begin n_fail++; $display("FAIL ccw1_speed got %0d want 2", bus.speed); end
        n_run++; if (upd_cnt - u0 !== 1) begin n_fail++; $display("FAIL ccw1_upd got %0d want 1", upd_cnt - u0); end
        for (int j = 0; j < 5; j++) begin
            u0 = upd_cnt;
            ccw_detent();
            exp_s = (1 - j < 0) ? 0 : 1 - j;
            exp_u = (j < 2) ? 1 : 0;
            n_run++;
            if (bus.speed !== 4'(exp_s)) begin
                n_fail++; $display("FAIL ccw_speed[%0d] got %0d want %0d", j, bus.speed, exp_s);
            end
            n_run++;
            if (upd_cnt - u0 !== exp_u) begin
                n_fail++; $display("FAIL ccw_upd[%0d] got %0d want %0d", j, upd_cnt - u0, exp_u);
            end
        end
    endtask

    task automatic test_bounce();
        int u0, e0;
        u0 = upd_cnt; e0 = err_cnt;
        repeat (10) begin
            bus.enc_a = 1'b1; tick(3);
            bus.enc_a = 1'b0; tick(3);
        end
        tick(20);
        n_run++; if (bus.speed !== 4'd0) begin n_fail++; $display("FAIL glitch_speed got %0d want 0", bus.speed); end
        n_run++; if (upd_cnt - u0 !== 0) begin n_fail++; $display("FAIL glitch_upd got %0d want 0", upd_cnt - u0); end
        n_run++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_err got %0d want 0", err_cnt - e0); end
        cw_detent();
        n_run++; if (bus.speed !== 4'd1) begin n_fail++; $display("FAIL glitch_then_cw got %0d want 1", bus.speed); end
        u0 = upd_cnt;
        bus.btn_dir = 1'b1; tick(2);
        bus.btn_dir = 1'b0; tick(2);
        bus.btn_dir = 1'b1; tick(20);
        n_run++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL btn_dir got %b want 1", bus.dir); end
        n_run++; if (upd_cnt - u0 !== 1) begin n_fail++; $display("FAIL btn_upd got %0d want 1", upd_cnt - u0); end
        u0 = upd_cnt;
        bus.btn_dir = 1'b0; tick(20);
        n_run++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL btn_release_dir got %b want 1", bus.dir); end
        n_run++; if (upd_cnt - u0 !== 0) begin n_fail++; $display("FAIL btn_release_upd got %0d want 0", upd_cnt - u0); end
    endtask

    task automatic test_illegal();
        int u0, e0, lat;
        bit found;
        logic [3:0] s0;
        s0 = bus.speed;
        u0 = upd_cnt; e0 = err_cnt;
        enc_pos = 2;
        apply_pos();
        found = 1'b0; lat = -1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (!found && bus.err === 1'b1) begin found = 1'b1; lat = k; end
        end
        n_run++; if (!found || lat != 6) begin n_fail++; $display("FAIL err_latency got edge %0d want edge 6", lat); end
        n_run++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL err_pulses got %0d want 1", err_cnt - e0); end
        n_run++; if (bus.speed !== s0) begin n_fail++; $display("FAIL err_speed got %0d want %0d", bus.speed, s0); end
        n_run++; if (upd_cnt - u0 !== 0) begin n_fail++; $display("FAIL err_upd got %0d want 0", upd_cnt - u0); end
        u0 = upd_cnt;
        cw_detent();
        n_run++; if (bus.speed !== s0 + 4'd1) begin n_fail++; $display("FAIL post_err_speed got %0d want %0d", bus.speed, s0 + 4'd1); end
        n_run++; if (upd_cnt - u0 !== 1) begin n_fail++; $display("FAIL post_err_upd got %0d want 1", upd_cnt - u0); end
    endtask

    task automatic test_reset_mid();
        int u0;
        enc_pos = 0; apply_pos();
        rst = 1'b1; tick(2); rst = 1'b0; tick(5);
        repeat (3) cw_step();
        n_run++; if (bus.speed !== 4'd0) begin n_fail++; $display("FAIL mid_pre_speed got %0d want 0", bus.speed); end
        enc_pos = 0; apply_pos();
        tick(3);
        rst = 1'b1; tick(1); rst = 1'b0;
        n_run++; if (bus.speed !== 4'd0) begin n_fail++; $display("FAIL mid_rst_speed got %0d want 0", bus.speed); end
        n_run++; if (bus.upd !== 1'b0) begin n_fail++; $display("FAIL mid_rst_upd got %b want 0", bus.upd); end
        u0 = upd_cnt;
        tick(20);
        cw_step();
        n_run++; if (bus.speed !== 4'd0) begin n_fail++; $display("FAIL mid_step_speed got %0d want 0", bus.speed); end
        n_run++; if (upd_cnt - u0 !== 0) begin n_fail++; $display("FAIL mid_step_upd got %0d want 0", upd_cnt - u0); end
    endtask

    task automatic test_powerup_11();
        int u0, e0;
        enc_pos = 2; apply_pos();
        rst = 1'b1; tick(2); rst = 1'b0;
        u0 = upd_cnt; e0 = err_cnt;
        tick(20);
        n_run++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL pwr11_err got %0d want 1", err_cnt - e0); end
        n_run++; if (bus.speed !== 4'd0) begin n_fail++; $display("FAIL pwr11_speed got %0d want 0", bus.speed); end
        n_run++; if (upd_cnt - u0 !== 0) begin n_fail++; $display("FAIL pwr11_upd got %0d want 0", upd_cnt - u0); end
    endtask

    initial begin
        bus.enc_a   = 1'b0;
        bus.enc_b   = 1'b0;
        bus.btn_dir = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_cw_saturate();
        test_ccw_partial();
        test_bounce();
        test_illegal();
        test_reset_mid();
        test_powerup_11();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
